// File: rtl/iob_rst_seq_pkg.sv
// rtl/iob_rst_seq_pkg.sv - state encoding and width helpers for the reset sequencer
package iob_rst_seq_pkg;

    typedef enum logic [2:0] {
        ASSERT   = 3'd0,
        WAIT_ACK = 3'd1,
        GAP      = 3'd2,
        DONE     = 3'd3,
        ERR      = 3'd4
    } state_e;

    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int cnt_width(input int hold_cyc, input int timeout_cyc);
        int max_cyc;
        max_cyc = (hold_cyc > timeout_cyc) ? hold_cyc : timeout_cyc;
        return $clog2(max_cyc + 1);
    endfunction

endpackage

// File: rtl/iob_rst_seq_sync.sv
// rtl/iob_rst_seq_sync.sv - async-assert / sync-deassert reset synchroniser
module iob_rst_seq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic arstn_i,
    output logic rstn_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rstn_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/iob_rst_seq.sv
// rtl/iob_rst_seq.sv - ordered per-channel reset release followed by a global clock enable
// IOB_RST_SEQ_TIMEOUT_EN adds the ack timeout counter and the sticky ERR state.
module iob_rst_seq
    import iob_rst_seq_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int HOLD_CYC    = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                        clk_i,
    input  logic                        arstn_i,
    input  logic                        cke_i,
    input  logic                        soft_rst_i,
    input  logic [NUM_CH-1:0]           ack_i,
    output logic [NUM_CH-1:0]           rst_o,
    output logic                        cke_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o,
    output logic [ch_width(NUM_CH)-1:0] ch_o
);

    localparam int CH_W  = ch_width(NUM_CH);
    localparam int CNT_W = cnt_width(HOLD_CYC, TIMEOUT_CYC);

    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_RST = CNT_W'(HOLD_CYC);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
`ifdef IOB_RST_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LD   = CNT_W'(TIMEOUT_CYC);
`endif

    logic rst_n;

    iob_rst_seq_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk_i),
        .arstn_i(arstn_i),
        .rstn_o (rst_n)
    );

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [NUM_CH-1:0] rst_q, rst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef IOB_RST_SEQ_TIMEOUT_EN
    logic              err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        rst_d   = rst_q;
        case (state_q)
            ASSERT: begin
                rst_d = '1;
                if (cnt_q == '0) begin
                    state_d  = WAIT_ACK;
                    ch_d     = '0;
                    rst_d[0] = 1'b0;
`ifdef IOB_RST_SEQ_TIMEOUT_EN
                    cnt_d    = TMO_LD;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WAIT_ACK: begin
                if (ack_i[ch_q]) begin
                    if (ch_q == LAST_CH) begin
                        state_d = DONE;
                        rst_d   = '0;
                    end else begin
                        state_d = GAP;
                        ch_d    = ch_q + 1'b1;
                        cnt_d   = HOLD_LD;
                    end
`ifdef IOB_RST_SEQ_TIMEOUT_EN
                end else if (cnt_q == '0) begin
                    state_d = ERR;
                    rst_d   = '1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
`endif
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d     = WAIT_ACK;
                    rst_d[ch_q] = 1'b0;
`ifdef IOB_RST_SEQ_TIMEOUT_EN
                    cnt_d       = TMO_LD;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                rst_d = '0;
            end
`ifdef IOB_RST_SEQ_TIMEOUT_EN
            ERR: begin
                rst_d = '1;
            end
`endif
            default: begin
                state_d = ASSERT;
                cnt_d   = HOLD_LD;
                ch_d    = '0;
                rst_d   = '1;
            end
        endcase

        // Restart overrides whatever ack or timeout decided this cycle.
        if (soft_rst_i) begin
            state_d = ASSERT;
            cnt_d   = HOLD_LD;
            ch_d    = '0;
            rst_d   = '1;
        end

        busy_d = (state_d == ASSERT) || (state_d == WAIT_ACK) || (state_d == GAP);
        done_d = (state_d == DONE);
`ifdef IOB_RST_SEQ_TIMEOUT_EN
        err_d  = (state_d == ERR);
`endif
    end

    // Out of reset the counter starts one above the reload value so the
    // first edge after synchroniser release is spent as the load cycle.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ASSERT;
            cnt_q   <= HOLD_RST;
            ch_q    <= '0;
            rst_q   <= '1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef IOB_RST_SEQ_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
        end else if (cke_i) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            rst_q   <= rst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef IOB_RST_SEQ_TIMEOUT_EN
            err_q   <= err_d;
`endif
        end
    end

    assign rst_o  = rst_q;
    assign cke_o  = done_q;
    assign done_o = done_q;
    assign busy_o = busy_q;
    assign ch_o   = ch_q;
`ifdef IOB_RST_SEQ_TIMEOUT_EN
    assign err_o  = err_q;
`else
    assign err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_iob_rst_seq.sv
// tb/tb_iob_rst_seq.sv - scoreboard bench for iob_rst_seq (IOB_RST_SEQ_TIMEOUT_EN selects timeout expectations)
module tb_iob_rst_seq;

    logic       clk = 1'b0;
    logic       arstn_i;
    logic       cke_i;
    logic       soft_rst_i;
    logic [3:0] ack_i;
    logic [3:0] rst_o;
    logic       cke_o;
    logic       busy_o;
    logic       done_o;
    logic       err_o;
    logic [1:0] ch_o;

    int cyc    = -1;
    int n_run  = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    typedef struct {
        string      name;
        int         cyc;
        logic [9:0] v;
    } ev_t;

    ev_t exp_q[$];

    // Output tuple: {rst, cke, done, busy, err, ch}
    localparam logic [9:0] RST_V = {4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};

    int         nom_cyc[9] = '{2, 18, 19, 35, 36, 52, 53, 69, 70};
    logic [3:0] nom_rst[9] = '{4'hF, 4'hE, 4'hE, 4'hC, 4'hC, 4'h8, 4'h8, 4'h0, 4'h0};
    logic [1:0] nom_ch[9]  = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};

    iob_rst_seq #(
        .NUM_CH     (4),
        .HOLD_CYC   (16),
        .SYNC_STAGES(2),
        .TIMEOUT_CYC(64)
    ) dut (
        .clk_i     (clk),
        .arstn_i   (arstn_i),
        .cke_i     (cke_i),
        .soft_rst_i(soft_rst_i),
        .ack_i     (ack_i),
        .rst_o     (rst_o),
        .cke_o     (cke_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .ch_o      (ch_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= arstn_i ? cyc + 1 : -1;

    function automatic logic [9:0] outs();
        return {rst_o, cke_o, done_o, busy_o, err_o, ch_o};
    endfunction

    task automatic push_ev(input string n, input int c, input logic [3:0] r, input logic k,
                           input logic d, input logic b, input logic e, input logic [1:0] ch);
        ev_t x;
        x.name = n;
        x.cyc  = c;
        x.v    = {r, k, d, b, e, ch};
        exp_q.push_back(x);
    endtask

    task automatic push_nominal(input int last);
        for (int i = 0; i < 9; i++) begin
            if (nom_cyc[i] <= last)
                push_ev($sformatf("nominal@%0d", nom_cyc[i]), nom_cyc[i], nom_rst[i],
                        i == 8, i == 8, i != 8, 1'b0, nom_ch[i]);
        end
    endtask

    task automatic check(input string n, input logic [9:0] act, input logic [9:0] req);
        n_run++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", n, act, req);
        end
    endtask

    task automatic monitor();
        logic [9:0] prev;
        logic [9:0] cur;
        ev_t        e;
        prev = RST_V;
        forever begin
            @(negedge clk);
            cur = outs();
            if (!mon_en) begin
                prev = RST_V;
            end else if (cur !== prev) begin
                n_run++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change: cycle %0d outputs %h, required no change from %h",
                             cyc, cur, prev);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.v !== cur) begin
                        n_fail++;
                        $display("FAIL %s: cycle %0d outputs %h, required cycle %0d outputs %h",
                                 e.name, cyc, cur, e.cyc, e.v);
                    end
                end
                prev = cur;
            end
        end
    endtask

    task automatic run_to(input int n);
        int guard;
        guard = 0;
        while (cyc != n && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != n) begin
            n_run++;
            n_fail++;
            $display("FAIL run_to_%0d: cycle %0d reached, required %0d", n, cyc, n);
        end
    endtask

    task automatic start_run(input logic [3:0] ack);
        mon_en     = 1'b0;
        arstn_i    = 1'b0;
        soft_rst_i = 1'b0;
        cke_i      = 1'b1;
        ack_i      = ack;
        repeat (3) @(negedge clk);
        check("reset_state", outs(), RST_V);
        mon_en  = 1'b1;
        arstn_i = 1'b1;
    endtask

    task automatic end_run(input string n);
        n_run++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_pending: %0d events still expected, first %s at cycle %0d",
                     n, exp_q.size(), exp_q[0].name, exp_q[0].cyc);
        end
        exp_q.delete();
    endtask

    initial begin
        arstn_i    = 1'b0;
        cke_i      = 1'b1;
        soft_rst_i = 1'b0;
        ack_i      = '0;
        fork
            monitor();
        join_none

        // Asynchronous reset while in GAP, between clock edges.
        start_run(4'hF);
        push_nominal(40);
        run_to(40);
        #3;
        mon_en  = 1'b0;
        arstn_i = 1'b0;
        #1;
        check("async_reset_mid_gap", outs(), RST_V);
        end_run("async_mid_gap");

        // Full nominal sequence, also the restart after the async reset.
        start_run(4'hF);
        push_nominal(70);
        run_to(75);
        end_run("nominal");

        // Soft restart pulse during cycle 50.
        start_run(4'hF);
        push_nominal(50);
        push_ev("soft_assert", 51, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        push_ev("soft_rel0",   67, 4'hE, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        push_ev("soft_gap1",   68, 4'hE, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1);
        run_to(50);
        soft_rst_i = 1'b1;
        run_to(51);
        soft_rst_i = 1'b0;
        run_to(72);
        end_run("soft_rst");

        // ack[1] low through cycle 100.
        start_run(4'hD);
        push_nominal(35);
`ifdef IOB_RST_SEQ_TIMEOUT_EN
        push_ev("ack1_timeout", 100, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
`else
        push_ev("ack1_gap2",  102, 4'hC, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2);
        push_ev("ack1_rel2",  118, 4'h8, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2);
        push_ev("ack1_gap3",  119, 4'h8, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3);
        push_ev("ack1_rel3",  135, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3);
        push_ev("ack1_done",  136, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3);
`endif
        run_to(101);
        ack_i = 4'hF;
        run_to(140);
        end_run("late_ack");

        // cke_i low for ten cycles during ASSERT.
        start_run(4'hF);
        push_ev("cke_busy", 2,  4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        push_ev("cke_rel0", 28, 4'hE, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        push_ev("cke_gap1", 29, 4'hE, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1);
        run_to(4);
        cke_i = 1'b0;
        run_to(14);
        cke_i = 1'b1;
        run_to(31);
        end_run("cke_stall");

        // ack[2] never arrives; soft restart during cycle 120.
        start_run(4'hB);
        push_nominal(52);
`ifdef IOB_RST_SEQ_TIMEOUT_EN
        push_ev("tmo_err", 117, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
`endif
        push_ev("tmo_soft", 121, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        run_to(120);
        soft_rst_i = 1'b1;
        run_to(121);
        soft_rst_i = 1'b0;
        run_to(125);
        check("err_cleared", {9'd0, err_o}, 10'd0);
        end_run("timeout");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/iob_rst_seq.md
# iob_rst_seq

Parametrised reset and clock-enable sequencer for FPGA system tops. It takes a board or PS active-low asynchronous reset and produces NUM_CH active-high reset outputs. Each output is released in order, gated by per-channel ready acknowledges such as memory-calibration done or PLL lock. A global clock enable is raised only after the last channel is released. The block sits between the PS clock/reset pins and the system core, memory interconnect and peripheral wrappers, replacing hand-tied `cke = 1` and `arst = ~arstn` connections.

## Interface
- NUM_CH, 4: number of sequenced reset channels (1..16).
- HOLD_CYC, 16: cycles all resets are held after sync release, and the gap between channels (≥1).
- SYNC_STAGES, 2: reset synchroniser depth (≥2).
- TIMEOUT_CYC, 1024: max cycles waiting for an ack; only used with the timeout macro.
- clk_i  in  1  system clock.
- arstn_i  in  1  asynchronous active-low reset.
- cke_i  in  1  input clock enable; when low, the FSM and counters freeze and outputs hold.
- soft_rst_i  in  1  synchronous restart request, level-sampled.
- ack_i  in  NUM_CH  per-channel ready; ack_i[k] is sampled only while waiting on channel k.
- rst_o  out  NUM_CH  active-high channel resets; reset value all-ones.
- cke_o  out  1  global clock enable; reset 0.
- busy_o  out  1  sequence in progress; reset 0.
- done_o  out  1  all channels released; reset 0.
- err_o  out  1  ack timeout, sticky; reset 0.
- ch_o  out  CH_W=max(1,$clog2(NUM_CH))  channel currently waited on; reset 0.

## Operation
- arstn_i low: all outputs go to reset values asynchronously. Release is through the synchroniser; the internal reset deasserts SYNC_STAGES edges after arstn_i rises.
- FSM states are ASSERT, WAIT_ACK, GAP, DONE and ERR.
  - ASSERT: rst_o all ones, busy_o=1. Stays HOLD_CYC cycles, then goes to WAIT_ACK with ch=0 and clears rst_o[0] on the same edge.
  - WAIT_ACK: ack_i[ch]=1 goes to GAP with ch+1, or to DONE if ch=NUM_CH-1.
  - GAP: stays HOLD_CYC cycles, then goes to WAIT_ACK and clears rst_o[ch] on that edge.
  - DONE: cke_o=1, done_o=1, busy_o=0, rst_o all zeros.
  - ERR: rst_o all ones, cke_o=0, busy_o=0, err_o=1.
- soft_rst_i=1 in any state returns the FSM to ASSERT next edge. On that edge: rst_o all ones, cke_o=0, done_o=0, err_o cleared, counter reloaded, ch=0. If soft_rst_i is held, the FSM stays in ASSERT with the counter held at its load value.
- soft_rst_i wins over ack_i and over timeout on the same edge.
- Released channels never re-assert except through ASSERT or ERR. An ack dropping after use is ignored.
- Counter is $clog2(max(HOLD_CYC,TIMEOUT_CYC)+1) bits wide, down-counting, and saturates at 0.

## Timing
- Cycle 0 is the first rising edge with arstn_i high.
- Internal reset releases at edge SYNC_STAGES; rst_o[0] falls at edge SYNC_STAGES+HOLD_CYC.
- With ack already high, rst_o[k+1] falls HOLD_CYC+1 cycles after rst_o[k].
- done_o and cke_o rise 1 cycle after the edge sampling ack_i[NUM_CH-1]=1.
- All outputs are registered; there is no combinational path from ack_i, soft_rst_i or cke_i to any output.
- cke_i low stretches every interval by the number of low cycles.

## Configuration
- IOB_RST_SEQ_TIMEOUT_EN defined:
  - WAIT_ACK loads TIMEOUT_CYC on entry and decrements each enabled cycle.
  - When it reaches 0 with ack still low, the FSM goes to ERR next edge.
  - ERR is left only by soft_rst_i or arstn_i.
- Undefined: WAIT_ACK waits indefinitely, err_o is tied 0, ERR is unreachable and not synthesised.

## Structure
- Package iob_rst_seq_pkg holds:
  - the state encoding constants (ASSERT=0, WAIT_ACK=1, GAP=2, DONE=3, ERR=4; 3-bit);
  - the CH_W and counter-width derivation functions.
- Sub-module iob_rst_seq_sync: SYNC_STAGES-deep async-assert/sync-deassert synchroniser producing the internal active-low reset.

## Test plan
- NUM_CH=4, HOLD_CYC=16, SYNC_STAGES=2, ack_i=4'hF -> rst_o[0..3] fall at cycles 18, 35, 52, 69; done_o and cke_o rise at cycle 70; ch_o steps 0..3.
- ack_i[1] held low until cycle 100 -> rst_o[1] falls at cycle 35, rst_o[2] at cycle 118, busy_o high throughout.
- soft_rst_i pulse at cycle 50 -> rst_o=4'hF and cke_o=0 at cycle 51; rst_o[0] falls again at cycle 67.
- With IOB_RST_SEQ_TIMEOUT_EN, TIMEOUT_CYC=64, ack_i[2]=0 -> err_o=1 and rst_o=4'hF at cycle 117; soft_rst_i clears err_o.
- arstn_i driven low mid-GAP, between clock edges -> rst_o=4'hF, cke_o=0 and done_o=0 immediately; restart timing as in the first scenario.
- cke_i low for 10 cycles during ASSERT -> rst_o[0] falls at cycle 28.
